// File: rtl/decode_scoreboard.sv
// Decode-stage scoreboard: pending-write counters for scalar/vector registers and CC,
// issue grant/stall, and a branch-hold FSM. Define SCOREBOARD_WB_BYPASS_EN for same-cycle retire bypass.
module decode_scoreboard #(
  parameter int NUM_RF    = 16,
  parameter int NUM_VRF   = 64,
  parameter int CNT_WIDTH = 2
) (
  input  logic                       I_CLOCK,
  input  logic                       I_RESET,
  input  logic                       I_Issue,
  input  logic [$clog2(NUM_RF)-1:0]  I_Src1RegIdx,
  input  logic [$clog2(NUM_RF)-1:0]  I_Src2RegIdx,
  input  logic                       I_Src1Read,
  input  logic                       I_Src2Read,
  input  logic [$clog2(NUM_VRF)-1:0] I_VSrc1Idx,
  input  logic [$clog2(NUM_VRF)-1:0] I_VSrc2Idx,
  input  logic                       I_VSrc1Read,
  input  logic                       I_VSrc2Read,
  input  logic                       I_CCRead,
  input  logic [$clog2(NUM_RF)-1:0]  I_DestRegIdx,
  input  logic                       I_DestWrite,
  input  logic [$clog2(NUM_VRF)-1:0] I_DestVRegIdx,
  input  logic                       I_DestVWrite,
  input  logic                       I_CCWrite,
  input  logic                       I_IsBranch,
  input  logic [$clog2(NUM_RF)-1:0]  I_WriteBackRegIdx,
  input  logic                       I_RegWEn,
  input  logic [$clog2(NUM_VRF)-1:0] I_WriteBackVRegIdx,
  input  logic                       I_VRegWEn,
  input  logic                       I_CCWEn,
  input  logic                       I_WriteBackPCEn,
  input  logic                       I_GPUStallSignal,
  output logic                       O_IssueGrant,
  output logic                       O_DepStallSignal,
  output logic                       O_BranchStallSignal,
  output logic                       O_Error
);

  localparam int RW = $clog2(NUM_RF);
  localparam int VW = $clog2(NUM_VRF);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {IDLE, BR_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   scnt_q [NUM_RF];
  logic [CNT_WIDTH-1:0]   scnt_d [NUM_RF];
  logic [CNT_WIDTH-1:0]   vcnt_q [NUM_VRF];
  logic [CNT_WIDTH-1:0]   vcnt_d [NUM_VRF];
  logic [CNT_WIDTH-1:0]   cccnt_q, cccnt_d;
  logic                   err_q, err_d;

  logic hazard, grant, sat_hz, src_hz;

  // A source is still pending unless its only outstanding write retires this cycle (bypass).
  function automatic logic pend(input logic [CNT_WIDTH-1:0] cnt, input logic ret);
    pend = (cnt != CNT_ZERO) && !(BYPASS && ret && (cnt == CNT_ONE));
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_upd(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic inc, input logic dec);
    cnt_upd = cnt;
    if (inc && !dec && cnt != CNT_MAX)       cnt_upd = cnt + CNT_ONE;
    else if (dec && !inc && cnt != CNT_ZERO) cnt_upd = cnt - CNT_ONE;
  endfunction

  function automatic logic cnt_err(input logic [CNT_WIDTH-1:0] cnt,
                                   input logic inc, input logic dec);
    cnt_err = (dec && !inc && cnt == CNT_ZERO) || (inc && !dec && cnt == CNT_MAX);
  endfunction

  always_comb begin
    src_hz = (I_Src1Read  && pend(scnt_q[I_Src1RegIdx],
                                  I_RegWEn && (I_WriteBackRegIdx == I_Src1RegIdx)))
           | (I_Src2Read  && pend(scnt_q[I_Src2RegIdx],
                                  I_RegWEn && (I_WriteBackRegIdx == I_Src2RegIdx)))
           | (I_VSrc1Read && pend(vcnt_q[I_VSrc1Idx],
                                  I_VRegWEn && (I_WriteBackVRegIdx == I_VSrc1Idx)))
           | (I_VSrc2Read && pend(vcnt_q[I_VSrc2Idx],
                                  I_VRegWEn && (I_WriteBackVRegIdx == I_VSrc2Idx)))
           | (I_CCRead    && pend(cccnt_q, I_CCWEn));
    // Saturation uses the raw count so a full counter never sees a grant.
    sat_hz = (I_DestWrite  && scnt_q[I_DestRegIdx]  == CNT_MAX)
           | (I_DestVWrite && vcnt_q[I_DestVRegIdx] == CNT_MAX)
           | (I_CCWrite    && cccnt_q == CNT_MAX);
    hazard = src_hz | sat_hz;
    grant  = I_Issue && !hazard && !I_GPUStallSignal && (state_q == IDLE);
  end

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_RF; i++) begin
      scnt_d[i] = cnt_upd(scnt_q[i], grant && I_DestWrite && (I_DestRegIdx == RW'(i)),
                          I_RegWEn && (I_WriteBackRegIdx == RW'(i)));
      if (cnt_err(scnt_q[i], grant && I_DestWrite && (I_DestRegIdx == RW'(i)),
                  I_RegWEn && (I_WriteBackRegIdx == RW'(i))))
        err_d = 1'b1;
    end
    for (int j = 0; j < NUM_VRF; j++) begin
      vcnt_d[j] = cnt_upd(vcnt_q[j], grant && I_DestVWrite && (I_DestVRegIdx == VW'(j)),
                          I_VRegWEn && (I_WriteBackVRegIdx == VW'(j)));
      if (cnt_err(vcnt_q[j], grant && I_DestVWrite && (I_DestVRegIdx == VW'(j)),
                  I_VRegWEn && (I_WriteBackVRegIdx == VW'(j))))
        err_d = 1'b1;
    end
    cccnt_d = cnt_upd(cccnt_q, grant && I_CCWrite, I_CCWEn);
    if (cnt_err(cccnt_q, grant && I_CCWrite, I_CCWEn)) err_d = 1'b1;
  end

  always_comb begin
    state_d             = state_q;
    O_BranchStallSignal = 1'b0;
    case (state_q)
      IDLE: begin
        O_BranchStallSignal = I_Issue && I_IsBranch;
        if (grant && I_IsBranch) state_d = BR_WAIT;
      end
      BR_WAIT: begin
        O_BranchStallSignal = 1'b1;
        if (I_WriteBackPCEn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state_q <= IDLE;
      scnt_q  <= '{default: '0};
      vcnt_q  <= '{default: '0};
      cccnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      vcnt_q  <= vcnt_d;
      cccnt_q <= cccnt_d;
      err_q   <= err_d;
    end
  end

  assign O_IssueGrant     = grant;
  assign O_DepStallSignal = I_Issue && hazard;
  assign O_Error          = err_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Table-driven bench for decode_scoreboard: per-cycle input/expected records checked through a queue,
// plus a bounded-wait producer/consumer sequence.
module tb_decode_scoreboard;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, issue, s1r, s2r, v1r, v2r, ccr, dw, vdw, ccw, br, wbe, vwbe, ccwe, pcen, gst;
  logic [3:0] s1, s2, d, wb;
  logic [5:0] v1, v2, vd, vwb;
  logic grant, dep, brs, err;

  decode_scoreboard dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_Issue(issue),
    .I_Src1RegIdx(s1), .I_Src2RegIdx(s2), .I_Src1Read(s1r), .I_Src2Read(s2r),
    .I_VSrc1Idx(v1), .I_VSrc2Idx(v2), .I_VSrc1Read(v1r), .I_VSrc2Read(v2r),
    .I_CCRead(ccr), .I_DestRegIdx(d), .I_DestWrite(dw),
    .I_DestVRegIdx(vd), .I_DestVWrite(vdw), .I_CCWrite(ccw), .I_IsBranch(br),
    .I_WriteBackRegIdx(wb), .I_RegWEn(wbe), .I_WriteBackVRegIdx(vwb), .I_VRegWEn(vwbe),
    .I_CCWEn(ccwe), .I_WriteBackPCEn(pcen), .I_GPUStallSignal(gst),
    .O_IssueGrant(grant), .O_DepStallSignal(dep), .O_BranchStallSignal(brs), .O_Error(err)
  );

  typedef struct {
    string      name;
    logic       rst, issue, gst, s1r, s2r, dw, v1r, v2r, vdw, ccr, ccw, br, wbe, vwbe, ccwe, pcen;
    logic [3:0] s1, s2, d, wb;
    logic [5:0] v1, v2, vd, vwb;
    logic [3:0] exp;  // {grant, dep, brs, err}
  } vec_t;

  vec_t       tbl[$];
  logic [3:0] expq[$];
  string      nameq[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t nv(string n);
    vec_t v;
    v.name = n;
    {v.rst, v.issue, v.gst, v.s1r, v.s2r, v.dw, v.v1r, v.v2r} = '0;
    {v.vdw, v.ccr, v.ccw, v.br, v.wbe, v.vwbe, v.ccwe, v.pcen} = '0;
    {v.s1, v.s2, v.d, v.wb} = '0;
    {v.v1, v.v2, v.vd, v.vwb} = '0;
    v.exp = 4'b0000;
    return v;
  endfunction

  function automatic vec_t wr(string n, logic [3:0] r, logic [3:0] e);
    vec_t v = nv(n);
    v.issue = 1'b1; v.dw = 1'b1; v.d = r; v.exp = e;
    return v;
  endfunction

  function automatic vec_t rd(string n, logic [3:0] r, logic [3:0] e);
    vec_t v = nv(n);
    v.issue = 1'b1; v.s1r = 1'b1; v.s1 = r; v.exp = e;
    return v;
  endfunction

  function automatic vec_t ret(string n, logic [3:0] r, logic [3:0] e);
    vec_t v = nv(n);
    v.wbe = 1'b1; v.wb = r; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; issue = v.issue; gst = v.gst;
    s1 = v.s1; s2 = v.s2; s1r = v.s1r; s2r = v.s2r;
    v1 = v.v1; v2 = v.v2; v1r = v.v1r; v2r = v.v2r;
    d = v.d; dw = v.dw; vd = v.vd; vdw = v.vdw;
    ccr = v.ccr; ccw = v.ccw; br = v.br;
    wb = v.wb; wbe = v.wbe; vwb = v.vwb; vwbe = v.vwbe; ccwe = v.ccwe; pcen = v.pcen;
  endtask

  task automatic check_out(input string n, input logic [3:0] e);
    total++;
    if ({grant, dep, brs, err} !== e) begin
      bad++;
      $display("FAIL %s: got grant/dep/br/err=%b required %b", n, {grant, dep, brs, err}, e);
    end
  endtask

  vec_t v;
  int   gcyc;

  initial begin
    drive(nv("init"));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and producer -> consumer dependence on R1
    tbl.push_back(nv("reset_state"));
    v = wr("add_r1", 4'd1, 4'b1000); v.s1r = 1; v.s1 = 4'd2; v.s2r = 1; v.s2 = 4'd3; tbl.push_back(v);
    v = wr("dep_c1", 4'd4, 4'b0100); v.s1r = 1; v.s1 = 4'd1; v.s2r = 1; v.s2 = 4'd5; tbl.push_back(v);
    v.name = "dep_c2"; tbl.push_back(v);
    v.name = "dep_retire"; v.wbe = 1; v.wb = 4'd1; v.exp = BYP ? 4'b1000 : 4'b0100; tbl.push_back(v);
    v.name = "dep_after"; v.wbe = 0; v.issue = !BYP; v.exp = BYP ? 4'b0000 : 4'b1000; tbl.push_back(v);
    tbl.push_back(ret("ret_r4", 4'd4, 4'b0000));
    // Saturation on R6
    for (int i = 0; i < 3; i++) tbl.push_back(wr("sat_fill", 4'd6, 4'b1000));
    tbl.push_back(wr("sat_stall", 4'd6, 4'b0100));
    v = wr("sat_stall_ret", 4'd6, 4'b0100); v.wbe = 1; v.wb = 4'd6; tbl.push_back(v);
    tbl.push_back(wr("sat_regrant", 4'd6, 4'b1000));
    for (int i = 0; i < 3; i++) tbl.push_back(ret("sat_drain", 4'd6, 4'b0000));
    // Same-cycle grant and retire on R2 keeps the count at 1
    tbl.push_back(wr("r2_w1", 4'd2, 4'b1000));
    v = wr("r2_w_ret", 4'd2, 4'b1000); v.wbe = 1; v.wb = 4'd2; tbl.push_back(v);
    tbl.push_back(rd("r2_still1", 4'd2, 4'b0100));
    tbl.push_back(ret("r2_ret", 4'd2, 4'b0000));
    tbl.push_back(rd("r2_free", 4'd2, 4'b1000));
    // Conditional branch waiting on CC, then BR_WAIT hold
    v = nv("cc_write"); v.issue = 1; v.ccw = 1; v.exp = 4'b1000; tbl.push_back(v);
    v = nv("brz_stall"); v.issue = 1; v.ccr = 1; v.br = 1; v.exp = 4'b0110; tbl.push_back(v);
    v.name = "brz_ccret"; v.ccwe = 1; v.exp = BYP ? 4'b1010 : 4'b0110; tbl.push_back(v);
    v.name = "brz_next"; v.ccwe = 0; v.issue = !BYP; v.exp = BYP ? 4'b0010 : 4'b1010; tbl.push_back(v);
    tbl.push_back(wr("brwait_hold", 4'd7, 4'b0010));
    v = wr("brwait_pcen", 4'd7, 4'b0010); v.pcen = 1; tbl.push_back(v);
    tbl.push_back(wr("br_idle", 4'd7, 4'b1000));
    tbl.push_back(ret("ret_r7", 4'd7, 4'b0000));
    // Sticky error and reset clearing
    tbl.push_back(ret("ret_r9_zero", 4'd9, 4'b0000));
    tbl.push_back(nv("err_set")); tbl[$].exp = 4'b0001;
    tbl.push_back(wr("err_sticky_w10", 4'd10, 4'b1001));
    v = ret("rst_err", 4'd9, 4'b0001); v.rst = 1; tbl.push_back(v);
    tbl.push_back(rd("rst_cleared", 4'd10, 4'b1000));
    v = nv("br_jmp"); v.issue = 1; v.br = 1; v.exp = 4'b1010; tbl.push_back(v);
    v = nv("rst_brwait"); v.rst = 1; v.exp = 4'b0010; tbl.push_back(v);
    tbl.push_back(wr("after_rst_br", 4'd11, 4'b1000));
    tbl.push_back(ret("ret_r11", 4'd11, 4'b0000));
    // Downstream stall masks grant only
    v = wr("gpu_stall", 4'd12, 4'b0000); v.gst = 1; v.s1r = 1; v.s1 = 4'd13; tbl.push_back(v);
    tbl.push_back(rd("gpu_no_cnt", 4'd12, 4'b1000));
    v = rd("gpu_stall_dep", 4'd12, 4'b1000); v.dw = 1; v.d = 4'd12; tbl.push_back(v);
    v = rd("gpu_dep_kept", 4'd12, 4'b0100); v.gst = 1; tbl.push_back(v);
    tbl.push_back(ret("ret_r12", 4'd12, 4'b0000));
    // Vector dependence
    v = nv("vwr40"); v.issue = 1; v.vdw = 1; v.vd = 6'd40; v.exp = 4'b1000; tbl.push_back(v);
    v = nv("vdep40"); v.issue = 1; v.v2r = 1; v.v2 = 6'd40; v.exp = 4'b0100; tbl.push_back(v);
    v = nv("vret40"); v.vwbe = 1; v.vwb = 6'd40; tbl.push_back(v);
    v = nv("vfree40"); v.issue = 1; v.v1r = 1; v.v1 = 6'd40; v.v2r = 1; v.v2 = 6'd40;
    v.exp = 4'b1000; tbl.push_back(v);

    foreach (tbl[k]) begin
      drive(tbl[k]);
      expq.push_back(tbl[k].exp);
      nameq.push_back(tbl[k].name);
      @(negedge clk);
      check_out(nameq.pop_front(), expq.pop_front());
      @(posedge clk);
      #1;
    end

    // Consumer of R5 held until retire; grant cycle depends on bypass
    drive(wr("prod_r5", 4'd5, 4'b1000));
    @(negedge clk);
    check_out("prod_r5", 4'b1000);
    gcyc = -1;
    for (int c = 0; c < 10 && gcyc < 0; c++) begin
      @(posedge clk);
      #1;
      drive(rd("cons_r5", 4'd5, 4'b0000));
      wbe = (c == 2); wb = 4'd5;
      @(negedge clk);
      if (grant) gcyc = c;
    end
    total++;
    if (gcyc != (BYP ? 2 : 3)) begin
      bad++;
      $display("FAIL cons_r5_grant_cycle: got %0d required %0d", gcyc, BYP ? 2 : 3);
    end
    @(posedge clk);
    #1;
    drive(nv("idle_end"));
    @(negedge clk);
    check_out("idle_end", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
